sqrt_ctrl: RTL
==============

Name: sqrt_ctrl

Overview:
Control stage that sits directly upstream of the iterative square-root datapath (sqrt_proc).
- Accepts an operand via a start/ready handshake and holds it stable on the datapath's dt input.
- Drives the datapath busy strobe and watches its s-less-than-dt flag to decide when iteration ends.
- Captures the datapath result and presents it downstream with a valid/ack handshake, plus the iteration count.

Parameters:
DATA_W, 8, operand/result width; must match the datapath (8).
MAX_ITER, 16, iteration guard limit; used only when SQRT_CTRL_TIMEOUT_EN is defined.

Ports:
clk_i  in  1  clock; all logic on its rising edge
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  request; accepted on an edge where start_i && ready_o
operand_i  in  DATA_W  radicand; sampled on accept
ready_o  out  1  high only in IDLE
dp_dt_o  out  DATA_W  registered operand to datapath dt_i; stable from LOAD through DONE
dp_busy_o  out  1  datapath busy_i; high only in RUN
dp_less_i  in  1  datapath s_less_than_dt_o
dp_result_i  in  DATA_W  datapath dt_o
valid_o  out  1  result available; high only in DONE
result_o  out  DATA_W  captured result
iter_o  out  ITER_W  RUN cycles with dp_less_i=1; ITER_W = $clog2(MAX_ITER+1)
ack_i  in  1  downstream consume; effective only while valid_o=1

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - dp_dt_o, result_o and iter_o are 0.
  - valid_o=0, dp_busy_o=0, ready_o=1 on the first cycle after reset.
  - Reset mid-operation aborts immediately; any pending result is discarded.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE. All control outputs are Moore, decoded from registered state.
- IDLE:
  - On start_i=1: latch operand_i into dp_dt_o, clear iter, go to LOAD.
  - start_i is ignored in every other state.
- LOAD:
  - One cycle with dp_busy_o=0 and the operand already stable, so the datapath reinitialises d/s.
  - The busy rising edge therefore sees a settled dt.
  - Go to RUN unconditionally.
- RUN: dp_busy_o=1. Each edge:
  - dp_less_i=1: iter++ (saturating at all-ones), stay in RUN.
  - dp_less_i=0: capture dp_result_i into result_o on this same edge, i.e. the pre-update datapath value; go to DONE.
  - Datapath overshoot during the following busy-low cycle is harmless because the result is already captured.
- DONE:
  - valid_o=1; result_o and iter_o are held.
  - ack_i=1: go to IDLE; valid_o falls on the next cycle.
  - There is no IDLE bypass: back-to-back operations cost one idle cycle.
- Latency: with N flag-high RUN cycles, accept at edge 0, LOAD in cycle 1, RUN in cycles 2..N+2, valid_o high from cycle N+3.
- Operand 0: the datapath flag is low in the first RUN cycle, so N=0, result is dp_result_i, and valid_o is high at cycle 3.
- dp_less_i and dp_result_i are ignored outside RUN.

Optional Feature:
SQRT_CTRL_TIMEOUT_EN
- Defined:
  - Adds output timeout_o (1 bit, reset 0).
  - In RUN, when iter reaches MAX_ITER with dp_less_i still 1: go to DONE, set timeout_o=1, force result_o to all-ones.
  - timeout_o clears on the next accept.
- Undefined:
  - No timeout_o port and no guard.
  - RUN lasts until dp_less_i=0.
  - iter_o saturates at all-ones.

Decomposition:
- Package sqrt_pkg:
  - DATA_W default constant.
  - typedef enum logic [1:0] sqrt_state_t {IDLE, LOAD, RUN, DONE}.
  - ITER_W helper function.
- No sub-module is needed: the counter and capture registers stay inline.
- A wrapper sqrt_top instantiating sqrt_ctrl plus sqrt_proc is the integration point, not part of this block.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> ready_o=1, valid_o=0, dp_busy_o=0, result_o=0, iter_o=0.
- Basic run: start_i with operand 0x09; stub drives dp_less_i=1 for 2 RUN cycles, then 0 with dp_result_i=0x03 -> dp_dt_o=0x09 from cycle 1; dp_busy_o high exactly cycles 2-4; valid_o at cycle 5; result_o=0x03; iter_o=2.
- Zero operand: operand 0x00, dp_less_i=0 immediately, dp_result_i=0x00 -> busy for 1 cycle, valid_o at cycle 3, result_o=0, iter_o=0.
- Handshake: start_i pulsed during RUN and DONE is ignored; ack_i withheld 5 cycles -> valid_o and result_o stable; ack_i=1 -> ready_o=1 next cycle.
- Reset mid-RUN: rst_i asserted at iteration 3 -> next cycle IDLE, dp_busy_o=0, valid_o never asserted.
- With SQRT_CTRL_TIMEOUT_EN, MAX_ITER=4: dp_less_i stuck at 1 -> timeout_o=1, result_o=0xFF, iter_o=4, valid_o=1.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared constants, state type and sizing helper for the square-root control stage.
package sqrt_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } sqrt_state_t;

   // Width needed to count 0..max_iter inclusive.
   function automatic int iter_w(input int max_iter);
      return $clog2(max_iter + 1);
   endfunction

endpackage

// File: rtl/sqrt_ctrl.sv
// Control stage in front of the iterative square-root datapath: operand handshake, busy strobe,
// result capture and iteration count. Optional iteration guard enabled by SQRT_CTRL_TIMEOUT_EN.
module sqrt_ctrl
   import sqrt_pkg::*;
#(
   parameter int  DATA_W   = DATA_W_DEF,
   parameter int  MAX_ITER = 16,
   localparam int ITER_W   = iter_w(MAX_ITER)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] operand_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] dp_dt_o,
   output logic              dp_busy_o,
   input  logic              dp_less_i,
   input  logic [DATA_W-1:0] dp_result_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] result_o,
   input  logic              ack_i,
   output logic [ITER_W-1:0] iter_o
`ifdef SQRT_CTRL_TIMEOUT_EN
   ,
   output logic              timeout_o
`endif
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_LOAD = LOAD;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   localparam logic [ITER_W-1:0] ITER_ONES = '1;

   logic [1:0] state_q;

   // Moore decode straight from the state register keeps every strobe glitch-free.
   assign ready_o   = (state_q == ST_IDLE);
   assign dp_busy_o = (state_q == ST_RUN);
   assign valid_o   = (state_q == ST_DONE);

   // NOTE: every register here uses <= so all state updates see pre-edge values and
   // simulation matches the synthesized flops regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         dp_dt_o  <= '0;
         result_o <= '0;
         iter_o   <= '0;
`ifdef SQRT_CTRL_TIMEOUT_EN
         timeout_o <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  dp_dt_o <= operand_i;
                  iter_o  <= '0;
`ifdef SQRT_CTRL_TIMEOUT_EN
                  timeout_o <= 1'b0;
`endif
                  state_q <= ST_LOAD;
               end
            end

            // Busy stays low here so the datapath reinitialises against a settled dt.
            ST_LOAD: state_q <= ST_RUN;

            ST_RUN: begin
               if (dp_less_i) begin
`ifdef SQRT_CTRL_TIMEOUT_EN
                  if (iter_o == ITER_W'(MAX_ITER)) begin
                     timeout_o <= 1'b1;
                     result_o  <= '1;
                     state_q   <= ST_DONE;
                  end else if (iter_o != ITER_ONES) begin
                     iter_o <= iter_o + 1'b1;
                  end
`else
                  if (iter_o != ITER_ONES) begin
                     iter_o <= iter_o + 1'b1;
                  end
`endif
               end else begin
                  // Capture before the datapath's next update, so any overshoot is harmless.
                  result_o <= dp_result_i;
                  state_q  <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (ack_i) begin
                  state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
